// File: rtl/sg_chan_engine.sv
// Single-channel scatter-gather engine: walks a descriptor chain fetched through the
// channel FIFO and issues one ss_xfer per 8-byte beat of each described buffer.
module sg_chan_engine #(
  parameter int LEN_W = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        ctrl_start,
  input  logic        ctrl_abort,
  input  logic [31:3] desc_ptr,
  input  logic        ss_ready,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_dat64_i,
  output logic        ss_xfer,
  output logic [7:0]  sg_state,
  output logic [15:0] sg_desc,
  output logic [31:3] sg_addr,
  output logic [31:3] sg_next,
  output logic        done,
  output logic        err
);

  localparam logic [7:0] S_IDLE   = 8'h00;
  localparam logic [7:0] S_FETCH0 = 8'h01;
  localparam logic [7:0] S_FETCH1 = 8'h02;
  localparam logic [7:0] S_XFER   = 8'h04;
  localparam logic [7:0] S_NEXT   = 8'h08;
  localparam logic [7:0] S_DONE   = 8'h10;
  localparam logic [7:0] S_ERR    = 8'h80;

  logic [7:0]       state;
  logic [LEN_W-1:0] len;
  logic [31:3]      buf_addr;
  logic             eoc;
  logic             busy;

  // Descriptor words carry a few bits that have no meaning to the engine.
  logic unused_bits;
  assign unused_bits = ^{wbs_dat_i[2:1], wbs_dat64_i[2:0]};

  assign sg_state = state;
  assign busy     = (state == S_FETCH0) || (state == S_FETCH1) || (state == S_XFER);
  // Abort must squash the beat in the same cycle, before the state register reacts.
  assign ss_xfer  = ss_ready & ~ctrl_abort & busy;

  // NOTE: every register below uses non-blocking assignments so all of them update
  // together on the edge and no read within this block sees a half-updated value.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= S_IDLE;
      sg_desc  <= '0;
      sg_addr  <= '0;
      sg_next  <= '0;
      buf_addr <= '0;
      len      <= '0;
      eoc      <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (ctrl_abort) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE, S_DONE, S_ERR: begin
            if (ctrl_start) begin
              if (desc_ptr == '0) begin
                state <= S_ERR;
                err   <= 1'b1;
              end else begin
                sg_addr <= desc_ptr;
                state   <= S_FETCH0;
              end
            end
          end
          S_FETCH0: begin
            if (ss_xfer) begin
              sg_next  <= wbs_dat_i[31:3];
              eoc      <= wbs_dat_i[0];
              buf_addr <= wbs_dat64_i[31:3];
              sg_addr  <= sg_addr + 1'b1;
              state    <= S_FETCH1;
            end
          end
          S_FETCH1: begin
            if (ss_xfer) begin
              sg_desc <= wbs_dat_i[31:16];
              len     <= LEN_W'(wbs_dat_i[15:0]);
              sg_addr <= buf_addr;
              state   <= (wbs_dat_i[15:0] == 16'h0) ? S_NEXT : S_XFER;
            end
          end
          S_XFER: begin
            if (ss_xfer) begin
              sg_addr <= sg_addr + 1'b1;
              len     <= len - 1'b1;
              if (len == LEN_W'(1)) state <= S_NEXT;
            end
          end
          S_NEXT: begin
            if (eoc) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else if (sg_next == '0) begin
              state <= S_ERR;
              err   <= 1'b1;
            end else begin
              sg_addr <= sg_next;
              state   <= S_FETCH0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sg_chan_engine.sv
// Scoreboard bench for sg_chan_engine: a chain-walking reference model queues the
// expected beats and chain outcome; a negedge monitor pops and compares them.
module tb_sg_chan_engine;

  localparam logic [7:0] ST_IDLE   = 8'h00;
  localparam logic [7:0] ST_FETCH0 = 8'h01;
  localparam logic [7:0] ST_FETCH1 = 8'h02;
  localparam logic [7:0] ST_XFER   = 8'h04;
  localparam logic [7:0] ST_DONE   = 8'h10;
  localparam logic [7:0] ST_ERR    = 8'h80;

  typedef struct packed {
    logic [7:0]  st;
    logic [28:0] addr;
    logic [15:0] flags;
    logic        chk_flags;
  } beat_t;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        ctrl_start;
  logic        ctrl_abort;
  logic [31:3] desc_ptr;
  logic        ss_ready;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat64_i;
  logic        ss_xfer;
  logic [7:0]  sg_state;
  logic [15:0] sg_desc;
  logic [31:3] sg_addr;
  logic [31:3] sg_next;
  logic        done;
  logic        err;

  logic [63:0] mem [0:255];
  logic [28:0] addr_w;
  beat_t       exp_q[$];
  bit          end_q[$];   // 0 = done expected, 1 = err expected
  bit          sb_on;
  int          n_checks;
  int          n_fail;

  sg_chan_engine #(.LEN_W(16)) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .ctrl_start (ctrl_start),
    .ctrl_abort (ctrl_abort),
    .desc_ptr   (desc_ptr),
    .ss_ready   (ss_ready),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_dat64_i(wbs_dat64_i),
    .ss_xfer    (ss_xfer),
    .sg_state   (sg_state),
    .sg_desc    (sg_desc),
    .sg_addr    (sg_addr),
    .sg_next    (sg_next),
    .done       (done),
    .err        (err)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Memory behind the FIFO answers whatever beat address the engine presents.
  assign addr_w      = sg_addr;
  assign wbs_dat_i   = mem[addr_w[7:0]][31:0];
  assign wbs_dat64_i = mem[addr_w[7:0]][63:32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 64'h0;
  endtask

  // Descriptor: word0 lo = {next, eoc}, hi = buffer byte address; word1 lo = {flags, len}.
  task automatic put_desc(input logic [28:0] at, input logic [28:0] nxt, input bit eoc,
                          input logic [28:0] bufa, input logic [15:0] flags,
                          input logic [15:0] len);
    logic [28:0] at1;
    at1 = at + 29'd1;
    mem[at[7:0]]  = {bufa, 3'b000, nxt, 2'b00, eoc};
    mem[at1[7:0]] = {$urandom(), flags, len};
  endtask

  // Reference model: walk the chain as software would and list every beat it implies.
  task automatic model_chain(input logic [28:0] ptr);
    logic [28:0] p, p1, nxt, bufa;
    logic [63:0] w0, w1;
    if (ptr == 29'd0) begin
      end_q.push_back(1'b1);
      return;
    end
    p = ptr;
    for (int it = 0; it < 16; it++) begin
      p1 = p + 29'd1;
      w0 = mem[p[7:0]];
      w1 = mem[p1[7:0]];
      exp_q.push_back('{st: ST_FETCH0, addr: p,  flags: 16'h0, chk_flags: 1'b0});
      exp_q.push_back('{st: ST_FETCH1, addr: p1, flags: 16'h0, chk_flags: 1'b0});
      nxt  = w0[31:3];
      bufa = w0[63:35];
      for (int i = 0; i < int'(w1[15:0]); i++)
        exp_q.push_back('{st: ST_XFER, addr: bufa + 29'(i), flags: w1[31:16], chk_flags: 1'b1});
      if (w0[0]) begin
        end_q.push_back(1'b0);
        return;
      end
      if (nxt == 29'd0) begin
        end_q.push_back(1'b1);
        return;
      end
      p = nxt;
    end
  endtask

  always @(negedge wb_clk_i) begin
    if (sb_on && !wb_rst_i) begin
      if (ss_xfer) begin
        check("beat_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          beat_t b;
          b = exp_q.pop_front();
          check("beat_state", 64'(sg_state), 64'(b.st));
          check("beat_addr", 64'(sg_addr), 64'(b.addr));
          if (b.chk_flags) check("beat_desc", 64'(sg_desc), 64'(b.flags));
        end
      end
      if (done || err) begin
        check("end_expected", 64'(end_q.size() > 0), 64'd1);
        if (end_q.size() > 0) begin
          bit e;
          e = end_q.pop_front();
          check("end_kind_err", 64'(err), 64'(e));
          check("end_kind_done", 64'(done), 64'(!e));
          check("end_state", 64'(sg_state), e ? 64'(ST_ERR) : 64'(ST_DONE));
        end
      end
    end
  end

  task automatic start_chain(input logic [28:0] ptr, input bit model);
    if (model) model_chain(ptr);
    @(posedge wb_clk_i);
    #1;
    desc_ptr   = ptr;
    ctrl_start = 1'b1;
    @(posedge wb_clk_i);
    #1;
    ctrl_start = 1'b0;
  endtask

  // mode 0: ss_ready held high; mode 1: random ss_ready (~70% high).
  task automatic wait_end(input int mode);
    for (int c = 0; c < 1000; c++) begin
      @(negedge wb_clk_i);
      if (done || err) begin
        @(negedge wb_clk_i);
        check("pulse_one_cycle", 64'(done | err), 64'd0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        return;
      end
      @(posedge wb_clk_i);
      #1;
      ss_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 70);
    end
    check("chain_timeout", 64'd1, 64'd0);
    exp_q.delete();
    end_q.delete();
  endtask

  task automatic wait_state(input logic [7:0] st);
    for (int c = 0; c < 50; c++) begin
      @(negedge wb_clk_i);
      if (sg_state == st) return;
    end
    check("state_timeout", 64'(sg_state), 64'(st));
  endtask

  initial begin
    logic [28:0] held;
    n_checks   = 0;
    n_fail     = 0;
    sb_on      = 1'b0;
    wb_rst_i   = 1'b1;
    ctrl_start = 1'b0;
    ctrl_abort = 1'b0;
    desc_ptr   = '0;
    ss_ready   = 1'b1;
    clear_mem();

    #3;
    check("rst_state", 64'(sg_state), 64'(ST_IDLE));
    check("rst_desc", 64'(sg_desc), 64'd0);
    check("rst_addr", 64'(sg_addr), 64'd0);
    check("rst_next", 64'(sg_next), 64'd0);
    check("rst_xfer", 64'(ss_xfer), 64'd0);
    check("rst_done_err", 64'({done, err}), 64'd0);
    repeat (2) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    sb_on = 1'b1;

    // Single descriptor: buffer at byte 0x2000, 4 beats, flags 0xA5A5.
    put_desc(29'h20, 29'h0, 1'b1, 29'h400, 16'hA5A5, 16'd4);
    start_chain(29'h20, 1'b1);
    wait_end(0);
    check("single_final_state", 64'(sg_state), 64'(ST_DONE));
    check("single_desc", 64'(sg_desc), 64'hA5A5);

    // Two-descriptor chain: first -> 0x200 (beat 0x40), len 2; second eoc, len 1.
    clear_mem();
    put_desc(29'h20, 29'h40, 1'b0, 29'h600, 16'h1111, 16'd2);
    put_desc(29'h40, 29'h0, 1'b1, 29'hA00, 16'h2222, 16'd1);
    start_chain(29'h20, 1'b1);
    wait_end(0);

    // Backpressure in XFER: ready 1,0,0,1 and address frozen while low.
    clear_mem();
    put_desc(29'h30, 29'h0, 1'b1, 29'hE00, 16'h3333, 16'd4);
    ss_ready = 1'b1;
    start_chain(29'h30, 1'b1);
    wait_state(ST_XFER);
    held = sg_addr;
    @(posedge wb_clk_i);
    #1 ss_ready = 1'b0;
    @(negedge wb_clk_i);
    check("bp_xfer_low", 64'(ss_xfer), 64'd0);
    check("bp_addr_frozen1", 64'(sg_addr), 64'(held + 29'd1));
    @(posedge wb_clk_i);
    #1 ss_ready = 1'b0;
    @(negedge wb_clk_i);
    check("bp_addr_frozen2", 64'(sg_addr), 64'(held + 29'd1));
    @(posedge wb_clk_i);
    #1 ss_ready = 1'b1;
    @(negedge wb_clk_i);
    check("bp_xfer_resume", 64'(ss_xfer), 64'd1);
    wait_end(0);

    // Errors: null start pointer, then a chain ending with next=0 and eoc=0.
    start_chain(29'h0, 1'b1);
    wait_end(0);
    check("err_null_state", 64'(sg_state), 64'(ST_ERR));
    clear_mem();
    put_desc(29'h30, 29'h0, 1'b0, 29'hC00, 16'h4444, 16'd3);
    start_chain(29'h30, 1'b1);
    wait_end(0);
    check("err_chain_state", 64'(sg_state), 64'(ST_ERR));

    // Zero-length buffer, then address wrap at the top of the beat space.
    put_desc(29'h30, 29'h0, 1'b1, 29'h123, 16'h5555, 16'd0);
    start_chain(29'h30, 1'b1);
    wait_end(0);
    put_desc(29'h30, 29'h0, 1'b1, 29'h1FFFFFFF, 16'h6666, 16'd2);
    start_chain(29'h30, 1'b1);
    wait_end(0);

    // Abort in XFER: beat squashed that cycle, IDLE next, registers kept, no done.
    sb_on = 1'b0;
    put_desc(29'h30, 29'h0, 1'b1, 29'h800, 16'h7777, 16'd4);
    ss_ready = 1'b1;
    start_chain(29'h30, 1'b0);
    wait_state(ST_XFER);
    @(posedge wb_clk_i);
    #1 ctrl_abort = 1'b1;
    #1;
    check("abort_xfer_squashed", 64'(ss_xfer), 64'd0);
    held = sg_addr;
    @(posedge wb_clk_i);
    #1 ctrl_abort = 1'b0;
    check("abort_state_idle", 64'(sg_state), 64'(ST_IDLE));
    check("abort_addr_kept", 64'(sg_addr), 64'(held));
    check("abort_desc_kept", 64'(sg_desc), 64'h7777);
    for (int i = 0; i < 3; i++) begin
      @(negedge wb_clk_i);
      check("abort_no_pulse", 64'({done, err}), 64'd0);
    end

    // Reset while in FETCH1, then a clean restart.
    put_desc(29'h30, 29'h0, 1'b1, 29'h900, 16'h8888, 16'd2);
    ss_ready = 1'b0;
    start_chain(29'h30, 1'b0);
    ss_ready = 1'b1;
    @(posedge wb_clk_i);
    #1;
    check("pre_reset_fetch1", 64'(sg_state), 64'(ST_FETCH1));
    wb_rst_i = 1'b1;
    #1;
    check("mid_rst_state", 64'(sg_state), 64'(ST_IDLE));
    check("mid_rst_next", 64'(sg_next), 64'd0);
    check("mid_rst_addr", 64'(sg_addr), 64'd0);
    check("mid_rst_desc", 64'(sg_desc), 64'd0);
    check("mid_rst_xfer", 64'(ss_xfer), 64'd0);
    @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    sb_on = 1'b1;
    start_chain(29'h30, 1'b1);
    wait_end(0);

    // Random chains of 1..4 descriptors with random ready.
    for (int t = 0; t < 30; t++) begin
      int n, s0;
      logic [28:0] at, nx;
      bit bad_end;
      clear_mem();
      n = $urandom_range(1, 4);
      s0 = $urandom_range(0, 63);
      bad_end = ($urandom_range(0, 99) < 20);
      for (int i = 0; i < n; i++) begin
        at = 29'(8'h80 + 2 * ((s0 + 7 * i) % 64));
        nx = 29'(8'h80 + 2 * ((s0 + 7 * (i + 1)) % 64));
        if (i == n - 1)
          put_desc(at, 29'h0, !bad_end, 29'($urandom()), 16'($urandom()), 16'($urandom_range(0, 5)));
        else
          put_desc(at, nx, 1'b0, 29'($urandom()), 16'($urandom()), 16'($urandom_range(0, 5)));
      end
      start_chain(29'(8'h80 + 2 * s0), 1'b1);
      wait_end(1);
    end

    check("final_beats_left", 64'(exp_q.size()), 64'd0);
    check("final_ends_left", 64'(end_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
